// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the mult/div sequencer
//
// Holds the sequencer state encoding, the op codes carried with a request
// and the default watchdog sizing used by muldiv_seq and muldiv_watchdog.

package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        WB     = 3'd3,
        DONE   = 3'd4,
        EXC    = 3'd5,
        TOUT   = 3'd6
    } muldiv_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MAX_CYCLES_DEF = 40;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/muldiv_watchdog.sv
// rtl/muldiv_watchdog.sv - saturating wait-cycle counter with limit compare
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   clear          zero the counter (takes priority over enable)
//   enable         count one cycle; holds at all-ones instead of wrapping
//   expired        counter currently equals MAX_CYCLES

module muldiv_watchdog #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(MAX_CYCLES));

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - start/done sequencer for the shared mult/div unit and HI/LO
//
// Optional feature macro: MULDIV_TIMEOUT_EN (adds the WAIT watchdog and TOUT).
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   start, op             one-cycle request (op 0 = mult, 1 = div), taken in IDLE only
//   multend, divend       unit completion flags
//   divzero               divide-by-zero flag from the div unit
//   mloadab, dloadab      one-cycle unit load pulses
//   muxhigh, muxlow       HI/LO input select (0 = mult, 1 = div)
//   highwrite, lowwrite   HI/LO register loads
//   busy                  sequencer is not in IDLE
//   done                  one-cycle completion pulse (also on exception/timeout)
//   div_exc               one-cycle divide-by-zero pulse
//   timeout_err           one-cycle watchdog pulse (0 without the macro)
//
// Every output is decoded from the state register and op_q only, so no input
// has a combinational path to an output.

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    input  logic multend,
    input  logic divend,
    input  logic divzero,
    output logic mloadab,
    output logic dloadab,
    output logic muxhigh,
    output logic muxlow,
    output logic highwrite,
    output logic lowwrite,
    output logic busy,
    output logic done,
    output logic div_exc,
    output logic timeout_err
);

    muldiv_state_t state;
    muldiv_state_t state_nxt;
    logic          op_q;
    logic          wd_expired;

    if (2 ** CNT_W <= MAX_CYCLES) begin : g_bad_cnt_w
        $error("muldiv_seq: CNT_W too narrow to reach MAX_CYCLES");
    end

`ifdef MULDIV_TIMEOUT_EN
    // Cleared during LAUNCH so the first WAIT cycle sees a count of zero.
    muldiv_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == LAUNCH),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= OP_MULT;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                op_q <= op;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                // divzero outranks a divend in the same cycle; the other unit's
                // end flag is never looked at.
                if ((op_q == OP_DIV) && divzero) begin
                    state_nxt = EXC;
                end else if ((op_q == OP_DIV) ? divend : multend) begin
                    state_nxt = WB;
                end else if (wd_expired) begin
                    state_nxt = TOUT;
                end
            end
            WB:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            EXC:     state_nxt = IDLE;
            TOUT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mloadab   = 1'b0;
        dloadab   = 1'b0;
        highwrite = 1'b0;
        lowwrite  = 1'b0;
        done      = 1'b0;
        div_exc   = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        timeout_err = 1'b0;
`endif
        busy    = (state != IDLE);
        muxhigh = (state != IDLE) && op_q;
        muxlow  = (state != IDLE) && op_q;
        case (state)
            LAUNCH: begin
                mloadab = ~op_q;
                dloadab = op_q;
            end
            WB: begin
                highwrite = 1'b1;
                lowwrite  = 1'b1;
            end
            DONE: done = 1'b1;
            EXC: begin
                div_exc = 1'b1;
                done    = 1'b1;
            end
            TOUT: begin
                done = 1'b1;
`ifdef MULDIV_TIMEOUT_EN
                timeout_err = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule
